// File: rtl/prng_share_ctrl.sv
// prng_share_ctrl: owns a 6-bit Fibonacci LFSR and time-shares its 3-bit
// draws among NUM_REQ requesters.
//
// It runs a warm-up of WARMUP discarded steps after reset or a seed load,
// then serves requests round-robin with at most one draw per cycle.
// This block is the only place where the LFSR is stepped.
//
// Handshake:
//   - A requester raises req[i] and holds it until it sees rsp_valid[i].
//   - rsp_valid[i] is a registered, one-cycle pulse.
//   - rsp_data is valid only in that cycle.
//   - During the pulse cycle, requester i is masked from arbitration.
//     This lets it drop req without being granted twice.
//
// FSM visibility: ready is a registered copy of (state == S_SERVE) and is
// the observable state indicator. The only exception is the first cycle
// after reset with WARMUP=0, when ready is still 0 while already serving.
module prng_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         seed,
  input  logic               seed_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [2:0]         rsp_data,
  output logic               ready
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [5:0] DEFAULT_SEED = 6'b101100;
  localparam logic [5:0] LAST_CNT = (WARMUP == 0) ? 6'd0 : 6'(WARMUP - 1);
  localparam logic       START_READY = (WARMUP == 0) ? 1'b1 : 1'b0;
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic {
    S_WARMUP = 1'b0,
    S_SERVE  = 1'b1
  } state_t;

  localparam state_t START_STATE = (WARMUP == 0) ? S_SERVE : S_WARMUP;

  state_t              state;
  logic [5:0]          lfsr;
  logic [5:0]          cnt;
  logic [PW-1:0]       rr;

  logic [5:0]          lfsr_next;
  logic [5:0]          seed_sub;
  logic [2:0]          draw;
  logic [NUM_REQ-1:0]  elig;
  logic                gnt_found;
  logic [PW-1:0]       gnt_idx;
  logic [PW-1:0]       cand_idx;
  logic [PW-1:0]       rr_next;
  int                  cand;

  // LFSR step, seed substitution (an all-zero seed would lock up) and draw tap
  always_comb begin
    lfsr_next = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
    seed_sub  = (seed == 6'd0) ? DEFAULT_SEED : seed;
    draw      = {lfsr[1], lfsr[3], lfsr[5]};
  end

  // Round-robin search starting at rr; requesters being answered this cycle are masked
  always_comb begin
    elig      = req & ~rsp_valid;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = PW'(cand);
      if (!gnt_found && elig[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    rr_next = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PW'(1);
  end

  // Controller FSM: seed load has priority, then warm-up stepping or serving grants
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= START_STATE;
      lfsr      <= DEFAULT_SEED;
      cnt       <= '0;
      rr        <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      ready     <= 1'b0;
    end else if (seed_load) begin
      state     <= START_STATE;
      lfsr      <= seed_sub;
      cnt       <= '0;
      rsp_valid <= '0;
      ready     <= START_READY;
    end else if (state == S_WARMUP) begin
      lfsr      <= lfsr_next;
      cnt       <= cnt + 6'd1;
      rsp_valid <= '0;
      if (cnt == LAST_CNT) begin
        state <= S_SERVE;
        ready <= 1'b1;
      end
    end else begin
      ready <= 1'b1;
      if (gnt_found) begin
        rsp_valid <= ONE_HOT0 << gnt_idx;
        rsp_data  <= draw;
        lfsr      <= lfsr_next;
        rr        <= rr_next;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule
